// File: rtl/riscv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_ctrl_pkg
// Description : Opcode constants, control-field encodings and the packed
//               control bundle shared by the RV32I decode stage.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_ctrl_pkg;

    // RV32I base opcodes (instruction[6:0])
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] c_OP_IALU   = 7'b0010011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;

    // Immediate format select
    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_src_e;

    // Writeback source select
    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    // ALU operation class
    typedef enum logic [1:0] {
        ALU_ADD    = 2'b00,
        ALU_SUB    = 2'b01,
        ALU_FUNCT  = 2'b10,
        ALU_PASS_B = 2'b11
    } alu_op_e;

    // Full control bundle handed across the ID/EX boundary
    typedef struct packed {
        logic        reg_write;
        logic        alu_src;
        logic        alu_a_pc;
        logic        mem_write;
        logic        branch;
        logic        jump;
        logic        illegal;
        imm_src_e    imm_src;
        result_src_e result_src;
        alu_op_e     alu_op;
    } ctrl_bundle_t;

    // All-zero bundle: the base every decode starts from
    localparam ctrl_bundle_t c_CTRL_NOP = '0;

endpackage : riscv_ctrl_pkg
`default_nettype wire

// File: rtl/ctrl_decode_comb.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_decode_comb
// Description : Purely combinational RV32I opcode -> control bundle decoder.
//               Jump and upper-immediate groups can be compiled out, in which
//               case those opcodes decode as illegal.
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_decode_comb
    import riscv_ctrl_pkg::*;
#(
    parameter bit EN_JUMP  = 1'b1,
    parameter bit EN_UPPER = 1'b1
) (
    input  logic [6:0]   i_op,
    output ctrl_bundle_t o_ctrl
);

    // Opcode decode; anything unrecognised or disabled is flagged illegal
    // with every control bit left at zero.
    always_comb begin
        o_ctrl = c_CTRL_NOP;
        case (i_op)
            c_OP_LOAD: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.alu_src    = 1'b1;
                o_ctrl.imm_src    = IMM_I;
                o_ctrl.result_src = RES_MEM;
                o_ctrl.alu_op     = ALU_ADD;
            end
            c_OP_STORE: begin
                o_ctrl.alu_src    = 1'b1;
                o_ctrl.mem_write  = 1'b1;
                o_ctrl.imm_src    = IMM_S;
            end
            c_OP_RTYPE: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.alu_op     = ALU_FUNCT;
            end
            c_OP_IALU: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.alu_src    = 1'b1;
                o_ctrl.alu_op     = ALU_FUNCT;
            end
            c_OP_BRANCH: begin
                o_ctrl.branch     = 1'b1;
                o_ctrl.imm_src    = IMM_B;
                o_ctrl.alu_op     = ALU_SUB;
            end
            c_OP_JAL: begin
                if (EN_JUMP) begin
                    o_ctrl.reg_write  = 1'b1;
                    o_ctrl.jump       = 1'b1;
                    o_ctrl.imm_src    = IMM_J;
                    o_ctrl.result_src = RES_PC4;
                end else begin
                    o_ctrl.illegal    = 1'b1;
                end
            end
            c_OP_JALR: begin
                if (EN_JUMP) begin
                    o_ctrl.reg_write  = 1'b1;
                    o_ctrl.jump       = 1'b1;
                    o_ctrl.alu_src    = 1'b1;
                    o_ctrl.imm_src    = IMM_I;
                    o_ctrl.result_src = RES_PC4;
                    o_ctrl.alu_op     = ALU_ADD;
                end else begin
                    o_ctrl.illegal    = 1'b1;
                end
            end
            c_OP_LUI: begin
                if (EN_UPPER) begin
                    o_ctrl.reg_write  = 1'b1;
                    o_ctrl.alu_src    = 1'b1;
                    o_ctrl.imm_src    = IMM_U;
                    o_ctrl.alu_op     = ALU_PASS_B;
                end else begin
                    o_ctrl.illegal    = 1'b1;
                end
            end
            c_OP_AUIPC: begin
                if (EN_UPPER) begin
                    o_ctrl.reg_write  = 1'b1;
                    o_ctrl.alu_src    = 1'b1;
                    o_ctrl.alu_a_pc   = 1'b1;
                    o_ctrl.imm_src    = IMM_U;
                    o_ctrl.alu_op     = ALU_ADD;
                end else begin
                    o_ctrl.illegal    = 1'b1;
                end
            end
            default: begin
                o_ctrl.illegal = 1'b1;
            end
        endcase
    end

endmodule : ctrl_decode_comb
`default_nettype wire

// File: rtl/ctrl_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_decode_stage
// Description : Registered RV32I control-decode stage. Decodes the opcode
//               ahead of a 2-entry skid buffer so that ready toward fetch
//               depends only on registered state. Counts accepted illegal
//               opcodes with a saturating counter.
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_decode_stage
    import riscv_ctrl_pkg::*;
#(
    parameter bit EN_JUMP  = 1'b1,
    parameter bit EN_UPPER = 1'b1,
    parameter int TAG_W    = 32,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_reg_write,
    output logic             out_alu_src,
    output logic             out_alu_a_pc,
    output logic             out_mem_write,
    output logic             out_branch,
    output logic             out_jump,
    output logic             out_illegal,
    output logic [2:0]       out_imm_src,
    output logic [1:0]       out_result_src,
    output logic [1:0]       out_alu_op,
    output logic [TAG_W-1:0] out_tag,
    output logic [CNT_W-1:0] illegal_count
);

    // Skid-buffer occupancy states
    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_TWO   = 2'd2;

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic             w_acc;
    logic             w_pop;
    ctrl_bundle_t     w_dec;
    ctrl_bundle_t     r_main;
    ctrl_bundle_t     r_skid;
    logic [TAG_W-1:0] r_main_tag;
    logic [TAG_W-1:0] r_skid_tag;
    logic [CNT_W-1:0] r_illegal_cnt;

    ctrl_decode_comb #(
        .EN_JUMP  (EN_JUMP),
        .EN_UPPER (EN_UPPER)
    ) u_decode (
        .i_op   (in_op),
        .o_ctrl (w_dec)
    );

    assign w_acc = in_valid & in_ready;
    assign w_pop = out_valid & out_ready;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; flush overrides every handshake
    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: if (w_acc) w_state_nxt = S_ONE;
                S_ONE: begin
                    if (w_acc && !w_pop) begin
                        w_state_nxt = S_TWO;
                    end else if (!w_acc && w_pop) begin
                        w_state_nxt = S_EMPTY;
                    end
                end
                S_TWO: if (w_pop) w_state_nxt = S_ONE;
                default: w_state_nxt = S_EMPTY;
            endcase
        end
    end

    // Handshake outputs decoded from the registered state only
    always_comb begin
        in_ready  = (r_state != S_TWO);
        out_valid = (r_state != S_EMPTY);
    end

    // Main/skid data registers: main always holds the oldest entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main     <= c_CTRL_NOP;
            r_skid     <= c_CTRL_NOP;
            r_main_tag <= '0;
            r_skid_tag <= '0;
        end else if (!flush) begin
            case (r_state)
                S_EMPTY: begin
                    if (w_acc) begin
                        r_main     <= w_dec;
                        r_main_tag <= in_tag;
                    end
                end
                S_ONE: begin
                    if (w_acc && w_pop) begin
                        r_main     <= w_dec;
                        r_main_tag <= in_tag;
                    end else if (w_acc) begin
                        r_skid     <= w_dec;
                        r_skid_tag <= in_tag;
                    end
                end
                S_TWO: begin
                    if (w_pop) begin
                        r_main     <= r_skid;
                        r_main_tag <= r_skid_tag;
                    end
                end
                default: ;
            endcase
        end
    end

    // Saturating count of accepted illegal opcodes; flushed inputs ignored
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_illegal_cnt <= '0;
        end else if (w_acc && !flush && w_dec.illegal && (r_illegal_cnt != c_CNT_MAX)) begin
            r_illegal_cnt <= r_illegal_cnt + 1'b1;
        end
    end

    assign out_reg_write  = r_main.reg_write;
    assign out_alu_src    = r_main.alu_src;
    assign out_alu_a_pc   = r_main.alu_a_pc;
    assign out_mem_write  = r_main.mem_write;
    assign out_branch     = r_main.branch;
    assign out_jump       = r_main.jump;
    assign out_illegal    = r_main.illegal;
    assign out_imm_src    = r_main.imm_src;
    assign out_result_src = r_main.result_src;
    assign out_alu_op     = r_main.alu_op;
    assign out_tag        = r_main_tag;
    assign illegal_count  = r_illegal_cnt;

endmodule : ctrl_decode_stage
`default_nettype wire

// File: tb/tb_ctrl_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_ctrl_decode_stage
// Description : Directed self-checking bench for ctrl_decode_stage. A second
//               instance with jump/upper groups disabled covers the illegal
//               decode of those opcodes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ctrl_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_valid_nj;
    logic [6:0]  in_op;
    logic [31:0] in_tag;
    logic        out_ready;
    logic        out_ready_nj;

    logic        in_ready, out_valid;
    logic        o_rw, o_as, o_ap, o_mw, o_br, o_jp, o_il;
    logic [2:0]  o_imm;
    logic [1:0]  o_res, o_aop;
    logic [31:0] out_tag;
    logic [7:0]  illegal_count;

    logic        in_ready_nj, out_valid_nj;
    logic        n_rw, n_as, n_ap, n_mw, n_br, n_jp, n_il;
    logic [2:0]  n_imm;
    logic [1:0]  n_res, n_aop;
    logic [31:0] out_tag_nj;
    logic [7:0]  illegal_count_nj;

    // Bundle layout: {rw,alu_src,alu_a_pc,mem_write,branch,jump,illegal}_imm_res_aluop
    logic [13:0] w_bund;
    logic [13:0] w_bund_nj;
    assign w_bund    = {o_rw, o_as, o_ap, o_mw, o_br, o_jp, o_il, o_imm, o_res, o_aop};
    assign w_bund_nj = {n_rw, n_as, n_ap, n_mw, n_br, n_jp, n_il, n_imm, n_res, n_aop};

    localparam logic [13:0] c_B_LOAD  = 14'b1100000_000_01_00;
    localparam logic [13:0] c_B_ILL   = 14'b0000001_000_00_00;

    logic [6:0]  ops  [9] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                              7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
    logic [13:0] exps [9] = '{14'b1100000_000_01_00,   // load
                              14'b0101000_001_00_00,   // store
                              14'b1000000_000_00_10,   // R-type
                              14'b1100000_000_00_10,   // I-ALU
                              14'b0000100_010_00_01,   // branch
                              14'b1000010_011_10_00,   // JAL
                              14'b1100010_000_10_00,   // JALR
                              14'b1100000_100_00_11,   // LUI
                              14'b1110000_100_00_00};  // AUIPC

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ctrl_decode_stage u_dut (
        .clk (clk), .rst (rst), .flush (flush),
        .in_valid (in_valid), .in_ready (in_ready), .in_op (in_op), .in_tag (in_tag),
        .out_valid (out_valid), .out_ready (out_ready),
        .out_reg_write (o_rw), .out_alu_src (o_as), .out_alu_a_pc (o_ap),
        .out_mem_write (o_mw), .out_branch (o_br), .out_jump (o_jp), .out_illegal (o_il),
        .out_imm_src (o_imm), .out_result_src (o_res), .out_alu_op (o_aop),
        .out_tag (out_tag), .illegal_count (illegal_count)
    );

    ctrl_decode_stage #(.EN_JUMP (1'b0), .EN_UPPER (1'b0)) u_dut_nj (
        .clk (clk), .rst (rst), .flush (flush),
        .in_valid (in_valid_nj), .in_ready (in_ready_nj), .in_op (in_op), .in_tag (in_tag),
        .out_valid (out_valid_nj), .out_ready (out_ready_nj),
        .out_reg_write (n_rw), .out_alu_src (n_as), .out_alu_a_pc (n_ap),
        .out_mem_write (n_mw), .out_branch (n_br), .out_jump (n_jp), .out_illegal (n_il),
        .out_imm_src (n_imm), .out_result_src (n_res), .out_alu_op (n_aop),
        .out_tag (out_tag_nj), .illegal_count (illegal_count_nj)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock, then settle past the edge before sampling
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_valid_nj = 1'b0;
        in_op = 7'h0; in_tag = '0; out_ready = 1'b1; out_ready_nj = 1'b1;

        // Reset state
        step(); step();
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_in_ready",  {31'd0, in_ready},  32'd1);
        check_eq("rst_bundle",    {18'd0, w_bund},    32'd0);
        check_eq("rst_tag",       out_tag,            32'd0);
        check_eq("rst_count",     {24'd0, illegal_count}, 32'd0);
        rst = 1'b0;
        step();

        // Stream every legal opcode back to back with out_ready high
        in_valid = 1'b1; in_op = ops[0]; in_tag = 32'h1000;
        for (int i = 0; i < 9; i++) begin
            step();
            check_eq($sformatf("stream_valid_%0d", i), {31'd0, out_valid}, 32'd1);
            check_eq($sformatf("stream_bund_%0d", i),  {18'd0, w_bund}, {18'd0, exps[i]});
            check_eq($sformatf("stream_tag_%0d", i),   out_tag, 32'h1000 + 32'(i * 4));
            if (i < 8) begin
                in_op  = ops[i+1];
                in_tag = 32'h1000 + 32'((i + 1) * 4);
            end else begin
                in_valid = 1'b0;
            end
        end
        step();
        check_eq("stream_drained", {31'd0, out_valid}, 32'd0);
        check_eq("stream_count",   {24'd0, illegal_count}, 32'd0);

        // Jump/upper disabled instance: JAL and LUI illegal, load still legal
        in_valid_nj = 1'b1; in_op = 7'b1101111; in_tag = 32'h55;
        step();
        check_eq("nj_jal_valid", {31'd0, out_valid_nj}, 32'd1);
        check_eq("nj_jal_bund",  {18'd0, w_bund_nj}, {18'd0, c_B_ILL});
        check_eq("nj_jal_tag",   out_tag_nj, 32'h55);
        check_eq("nj_jal_count", {24'd0, illegal_count_nj}, 32'd1);
        check_eq("nj_in_ready",  {31'd0, in_ready_nj}, 32'd1);
        in_op = 7'b0110111;
        step();
        check_eq("nj_lui_bund",  {18'd0, w_bund_nj}, {18'd0, c_B_ILL});
        check_eq("nj_lui_count", {24'd0, illegal_count_nj}, 32'd2);
        in_op = 7'b0000011;
        step();
        check_eq("nj_load_bund",  {18'd0, w_bund_nj}, {18'd0, c_B_LOAD});
        check_eq("nj_load_count", {24'd0, illegal_count_nj}, 32'd2);
        in_valid_nj = 1'b0;
        step();

        // Backpressure: two accepts fill the buffer, third waits
        out_ready = 1'b0; in_valid = 1'b1; in_op = 7'b0000011; in_tag = 32'h100;
        step();
        check_eq("skid_v1",   {31'd0, out_valid}, 32'd1);
        check_eq("skid_tag1", out_tag, 32'h100);
        check_eq("skid_rdy1", {31'd0, in_ready}, 32'd1);
        in_tag = 32'h104;
        step();
        check_eq("skid_rdy2", {31'd0, in_ready}, 32'd0);
        check_eq("skid_tag2", out_tag, 32'h100);
        in_tag = 32'h108;
        step();
        check_eq("skid_hold_tag", out_tag, 32'h100);
        check_eq("skid_hold_rdy", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        step();
        check_eq("skid_pop1_tag", out_tag, 32'h104);
        check_eq("skid_pop1_rdy", {31'd0, in_ready}, 32'd1);
        step();
        check_eq("skid_pop2_tag", out_tag, 32'h108);
        check_eq("skid_pop2_v",   {31'd0, out_valid}, 32'd1);
        in_valid = 1'b0;
        step();
        check_eq("skid_empty", {31'd0, out_valid}, 32'd0);

        // Flush while full, with an illegal opcode offered in the same cycle
        out_ready = 1'b0; in_valid = 1'b1; in_op = 7'b0110011; in_tag = 32'h200;
        step();
        in_tag = 32'h204;
        step();
        check_eq("flush_pre_rdy", {31'd0, in_ready}, 32'd0);
        flush = 1'b1; in_op = 7'h7F; in_tag = 32'h2FF;
        step();
        check_eq("flush_valid", {31'd0, out_valid}, 32'd0);
        check_eq("flush_rdy",   {31'd0, in_ready},  32'd1);
        check_eq("flush_count", {24'd0, illegal_count}, 32'd0);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step();
        check_eq("flush_stays_empty", {31'd0, out_valid}, 32'd0);
        in_valid = 1'b1; in_op = 7'b0100011; in_tag = 32'h300;
        step();
        check_eq("post_flush_tag", out_tag, 32'h300);
        in_valid = 1'b0;
        step();

        // Illegal-counter saturation
        in_valid = 1'b1; in_op = 7'h7F; in_tag = 32'h400;
        repeat (100) step();
        check_eq("sat_count_100", {24'd0, illegal_count}, 32'd100);
        check_eq("sat_bund",      {18'd0, w_bund}, {18'd0, c_B_ILL});
        repeat (200) step();
        check_eq("sat_count_300", {24'd0, illegal_count}, 32'd255);
        in_valid = 1'b0;
        step();

        // Asynchronous reset while the buffer is full
        out_ready = 1'b0; in_valid = 1'b1; in_op = 7'b0000011; in_tag = 32'h500;
        step();
        in_tag = 32'h504;
        step();
        in_valid = 1'b0;
        check_eq("arst_pre_rdy", {31'd0, in_ready}, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_valid", {31'd0, out_valid}, 32'd0);
        check_eq("arst_count", {24'd0, illegal_count}, 32'd0);
        check_eq("arst_rdy",   {31'd0, in_ready},  32'd1);
        check_eq("arst_tag",   out_tag, 32'd0);
        step();
        rst = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_ctrl_decode_stage
`default_nettype wire
